// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks a two-half-adder full-adder cell across
// WIDTH bit pairs LSB-first and presents the registered sum with a Done pulse.
module serial_add_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // The partial-sum register holds only the bits already produced; the
    // newest bit joins them combinationally when the result is loaded.
    localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;

    logic              hs, hc0, sum_bit, hc1, carry_new;
    logic [WIDTH-1:0]  sum_full;

    serial_add_ha u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),   .s_o(hs),      .c_o(hc0));
    serial_add_ha u_ha1 (.a_i(hs),     .b_i(carry_q),  .s_o(sum_bit), .c_o(hc1));
    assign carry_new = hc0 | hc1;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_full = sum_bit;
        end else begin : g_wn
            assign sum_full = {sum_bit, sum_q};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = operand_a_i;
                    b_d     = operand_b_i;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = (WIDTH > 1) ? SW'(sum_full >> 1) : '0;
                carry_d = carry_new;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = sum_full;
                    cout_d   = carry_new;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign result_o    = result_q;
    assign carry_out_o = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed sums.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] opa = '0, opb = '0;
    logic         busy, done, cout;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_r;
    logic         prev_c;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .operand_a_i(opa), .operand_b_i(opb),
        .busy_o(busy), .done_o(done), .result_o(result), .carry_out_o(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single operation: Start for one edge, then check Busy/Done timing and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec);
        @(negedge clk);
        start = 1'b1; opa = a; opb = b;
        @(posedge clk);
        #1 start = 1'b0; opa = 8'hC3; opb = 8'h3C;
        for (int j = 0; j < W; j++) begin
            @(negedge clk);
            chk({tag, "_busy"}, {busy, done}, 2'b10);
            if (j == 0) chk({tag, "_hold"}, {cout, result}, {prev_c, prev_r});
        end
        @(negedge clk);
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_res"}, {cout, result}, {ec, er});
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done}, 2'b00);
        prev_r = er; prev_c = ec;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, nd;
        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", {busy, done, cout, result}, '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        prev_r = '0; prev_c = 1'b0;

        run_op("add_5a_a5", 8'h5A, 8'hA5, 8'hFF, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("add_80_80", 8'h80, 8'h80, 8'h00, 1'b1);
        run_op("add_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 8'h80, 1'b0);
        run_op("add_c9_6e", 8'hC9, 8'h6E, 8'h37, 1'b1);

        // Start pulses during RUN and DONE are ignored
        @(negedge clk);
        start = 1'b1; opa = 8'h03; opb = 8'h04;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("busy_res", {cout, result}, {1'b0, 8'h07});
            end
            start = (j == 3 || j == 8) ? 1'b1 : 1'b0;
            opa = 8'hFF; opb = 8'hFF;
        end
        start = 1'b0;
        chk("busy_ndone", nd, 1);
        chk("busy_idle", {busy, done}, 2'b00);
        prev_r = 8'h07; prev_c = 1'b0;

        // Held Start: back-to-back operations every W+2 cycles
        @(negedge clk);
        start = 1'b1; opa = 8'h10; opb = 8'h20;
        @(posedge clk);
        d1 = -1; d2 = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done && d1 < 0) begin
                d1 = j;
                chk("held_res1", {cout, result}, {1'b0, 8'h30});
            end else if (done) begin
                d2 = j;
                chk("held_res2", {cout, result}, {1'b1, 8'h10});
            end
            if (busy && d1 >= 0) chk("held_keep", {cout, result}, {1'b0, 8'h30});
            if (j == 0) begin opa = 8'hF0; opb = 8'h20; end
            if (d1 >= 0 && busy) start = 1'b0;
        end
        start = 1'b0;
        chk("held_d1", d1, W);
        chk("held_gap", d2 - d1, W + 2);
        prev_r = 8'h10; prev_c = 1'b1;

        // Reset mid-operation aborts without Done
        @(negedge clk);
        start = 1'b1; opa = 8'hFF; opb = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", {busy, done, cout, result}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort_quiet", nd, 0);
        chk("abort_res", {cout, result}, '0);
        prev_r = '0; prev_c = 1'b0;
        run_op("add_01_02", 8'h01, 8'h02, 8'h03, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
